// File: rtl/blit_write_combiner.sv
// Write combiner between the blitter pixel pipeline and the memory write port.
// It merges byte/halfword pixel writes into DEPTH open word entries and emits word writes.
module blit_write_combiner #(
    parameter int ADDR_W = 26,
    parameter int BYTES  = 4,
    parameter int DEPTH  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [15:0]          in_data,
    input  logic                 in_size,
    input  logic                 in_active,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [8*BYTES-1:0]   out_data,
    output logic [BYTES-1:0]     out_byte_en,
    output logic                 idle
);
    localparam int OFF_W = $clog2(BYTES);
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     r_valid;
    logic [TAG_W-1:0]     r_tag   [DEPTH];
    logic [8*BYTES-1:0]   r_data  [DEPTH];
    logic [BYTES-1:0]     r_be    [DEPTH];
    // r_older[i][j] is set when entry i was allocated before entry j.
    logic [DEPTH-1:0]     r_older [DEPTH];

    logic                 r_out_valid;
    logic [ADDR_W-1:0]    r_out_addr;
    logic [8*BYTES-1:0]   r_out_data;
    logic [BYTES-1:0]     r_out_be;

    logic [OFF_W-1:0]     w_off;
    logic [OFF_W-1:0]     w_base;
    logic [TAG_W-1:0]     w_tag;
    logic [BYTES-1:0]     w_in_be;
    logic [8*BYTES-1:0]   w_in_data;
    logic [8*BYTES-1:0]   w_merge_data;

    logic                 w_hit_any;
    logic [IDX_W-1:0]     w_hit_idx;
    logic                 w_free_any;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_full_any;
    logic [IDX_W-1:0]     w_full_idx;
    logic [IDX_W-1:0]     w_old_idx;
    logic                 w_is_old;

    logic                 w_load_slot;
    logic                 w_need_evict;
    logic                 w_miss_evict;
    logic                 w_stall;
    logic                 w_flush_evict;
    logic                 w_eager_evict;
    logic                 w_conflict;
    logic                 w_accept;
    logic                 w_evict;
    logic [IDX_W-1:0]     w_evict_idx;
    logic [IDX_W-1:0]     w_alloc_idx;

    // Lane decode: place the incoming pixel on its byte lanes.
    always_comb begin
        w_off     = in_addr[OFF_W-1:0];
        w_tag     = in_addr[ADDR_W-1:OFF_W];
        w_base    = w_off;
        w_base[0] = 1'b0;
        w_in_be   = '0;
        w_in_data = '0;
        for (int k = 0; k < BYTES; k++) begin
            if (in_size) begin
                if (k == int'(w_base)) begin
                    w_in_be[k]         = 1'b1;
                    w_in_data[8*k +: 8] = in_data[7:0];
                end else if (k == int'(w_base) + 1) begin
                    w_in_be[k]         = 1'b1;
                    w_in_data[8*k +: 8] = in_data[15:8];
                end else begin
                    w_in_be[k]         = 1'b0;
                end
            end else if (k == int'(w_off)) begin
                w_in_be[k]         = 1'b1;
                w_in_data[8*k +: 8] = in_data[7:0];
            end else begin
                w_in_be[k]         = 1'b0;
            end
        end
    end

    // Entry search: tag hit, lowest free, lowest full and oldest valid entry.
    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_full_any = 1'b0;
        w_full_idx = '0;
        w_old_idx  = '0;
        w_is_old   = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i]) begin
                if (r_tag[i] == w_tag) begin
                    w_hit_any = 1'b1;
                    w_hit_idx = IDX_W'(i);
                end else begin
                    w_hit_any = w_hit_any;
                end
                if (&r_be[i]) begin
                    w_full_any = 1'b1;
                    w_full_idx = IDX_W'(i);
                end else begin
                    w_full_any = w_full_any;
                end
                w_is_old = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if ((j != i) && r_valid[j] && !r_older[i][j]) begin
                        w_is_old = 1'b0;
                    end else begin
                        w_is_old = w_is_old;
                    end
                end
                if (w_is_old) begin
                    w_old_idx = IDX_W'(i);
                end else begin
                    w_old_idx = w_old_idx;
                end
            end else begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Eviction arbitration and input handshake.
    always_comb begin
        w_load_slot   = !r_out_valid || out_ready;
        w_need_evict  = in_valid && !w_hit_any && !w_free_any;
        w_miss_evict  = w_need_evict && in_active && w_load_slot;
        w_stall       = w_need_evict && !w_load_slot;
        w_flush_evict = !w_miss_evict && !in_active && (|r_valid) && w_load_slot;
        w_eager_evict = !w_miss_evict && !w_flush_evict && w_full_any && w_load_slot;
        w_conflict    = in_valid && w_hit_any && w_eager_evict && (w_hit_idx == w_full_idx);
        in_ready      = in_active && !w_stall && !w_conflict;
        w_accept      = in_valid && in_ready;
        w_evict       = w_miss_evict || w_flush_evict || w_eager_evict;
        w_evict_idx   = w_eager_evict ? w_full_idx : w_old_idx;
        w_alloc_idx   = w_free_any ? w_free_idx : w_old_idx;
    end

    // Merge of the new lanes over the hit entry's current data.
    always_comb begin
        w_merge_data = r_data[w_hit_idx];
        for (int k = 0; k < BYTES; k++) begin
            if (w_in_be[k]) begin
                w_merge_data[8*k +: 8] = w_in_data[8*k +: 8];
            end else begin
                w_merge_data[8*k +: 8] = r_data[w_hit_idx][8*k +: 8];
            end
        end
    end

    // Entry storage: eviction clears first, a same-cycle reuse then reallocates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_evict && (w_evict_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_accept && w_hit_any && (w_hit_idx == IDX_W'(i))) begin
                    r_data[i] <= w_merge_data;
                    r_be[i]   <= r_be[i] | w_in_be;
                end else if (w_accept && !w_hit_any && (w_alloc_idx == IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_tag[i]   <= w_tag;
                    r_data[i]  <= w_in_data;
                    r_be[i]    <= w_in_be;
                    r_older[i] <= '0;
                end
                if (w_accept && !w_hit_any && (w_alloc_idx != IDX_W'(i))) begin
                    r_older[i][w_alloc_idx] <= 1'b1;
                end
            end
        end
    end

    // Output register: loads the evicted entry in a load slot, holds while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_be    <= '0;
        end else if (w_load_slot) begin
            if (w_evict) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= {r_tag[w_evict_idx], {OFF_W{1'b0}}};
                r_out_data  <= r_data[w_evict_idx];
                r_out_be    <= r_be[w_evict_idx];
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Output port mapping.
    always_comb begin
        out_valid   = r_out_valid;
        out_addr    = r_out_addr;
        out_data    = r_out_data;
        out_byte_en = r_out_be;
        idle        = !(|r_valid) && !r_out_valid;
    end

endmodule

// File: tb/tb_blit_write_combiner.sv
// Scoreboard bench for blit_write_combiner: a lane/queue reference model predicts
// handshakes and emitted words; a monitor checks every accepted output write.
module tb_blit_write_combiner;
    localparam int ADDR_W = 26;
    localparam int BYTES  = 4;
    localparam int DEPTH  = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ADDR_W-1:0]  in_addr = '0;
    logic [15:0]        in_data = '0;
    logic               in_size = 1'b0;
    logic               in_active = 1'b1;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ADDR_W-1:0]  out_addr;
    logic [31:0]        out_data;
    logic [3:0]         out_byte_en;
    logic               idle;

    blit_write_combiner #(.ADDR_W(ADDR_W), .BYTES(BYTES), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .in_size(in_size), .in_active(in_active),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_byte_en(out_byte_en), .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t seen_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  last_ready, last_idle;

    // Reference model: slots indexed like the hardware, age kept as a queue of slot numbers.
    bit                m_v   [DEPTH];
    logic [23:0]       m_tag [DEPTH];
    logic [7:0]        m_byte[DEPTH][BYTES];
    logic [3:0]        m_be  [DEPTH];
    int                m_age[$];
    bit                m_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lane_byte(input int k, input logic [1:0] off,
                                             input bit sz, input logic [15:0] d);
        if (sz && (k % 2 == 1)) return d[15:8];
        return d[7:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        m_age.delete();
        m_ov = 0;
    endtask

    // One clock cycle: drive inputs, check the combinational/registered view, advance the model.
    task automatic step(input bit iv, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                        input bit sz, input bit act, input bit rdy);
        int hit, fre, full, victim, idx;
        bit any_v, load, mev, stall, fev, eev, conf, exp_rdy, acc;
        logic [3:0] lanes;
        wr_t e;
        @(negedge clock);
        in_valid = iv; in_addr = a; in_data = d; in_size = sz; in_active = act; out_ready = rdy;
        cyc++;
        #1;
        hit = -1; fre = -1; full = -1; any_v = 0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_v[i]) begin
                any_v = 1;
                if (m_tag[i] == a[ADDR_W-1:2]) hit = i;
                if (m_be[i] == 4'hF) full = i;
            end else begin
                fre = i;
            end
        end
        lanes   = sz ? (4'b0011 << (a[1:0] & 2'b10)) : (4'b0001 << a[1:0]);
        load    = !m_ov || rdy;
        mev     = iv && act && hit < 0 && fre < 0 && load;
        stall   = iv && hit < 0 && fre < 0 && !load;
        fev     = !mev && !act && any_v && load;
        eev     = !mev && !fev && full >= 0 && load;
        conf    = iv && hit >= 0 && eev && hit == full;
        exp_rdy = act && !stall && !conf;
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("idle", idle, !any_v && !m_ov);
        last_ready = in_ready;
        last_idle  = idle;
        acc    = iv && exp_rdy;
        victim = (mev || fev) ? ((m_age.size() > 0) ? m_age[0] : -1) : (eev ? full : -1);
        @(posedge clock);
        if (victim >= 0) begin
            e.addr = {m_tag[victim], 2'b00};
            e.be   = m_be[victim];
            e.cyc  = 0;
            for (int k = 0; k < BYTES; k++) e.data[8*k +: 8] = m_be[victim][k] ? m_byte[victim][k] : 8'h00;
            exp_q.push_back(e);
            m_v[victim] = 0;
            for (int q = 0; q < m_age.size(); q++) begin
                if (m_age[q] == victim) begin
                    m_age.delete(q);
                    break;
                end
            end
            m_ov = 1;
        end else if (rdy) begin
            m_ov = 0;
        end
        if (acc) begin
            if (hit >= 0) begin
                idx = hit;
                m_be[idx] = m_be[idx] | lanes;
            end else begin
                idx = (fre >= 0) ? fre : victim;
                m_v[idx] = 1;
                m_tag[idx] = a[ADDR_W-1:2];
                m_be[idx] = lanes;
                m_age.push_back(idx);
            end
            for (int k = 0; k < BYTES; k++) if (lanes[k]) m_byte[idx][k] = lane_byte(k, a[1:0], sz, d);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; in_active = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_out_addr", out_addr, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_be", out_byte_en, '0);
        model_clear();
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic idle_steps(input int n, input bit act);
        for (int i = 0; i < n; i++) step(1'b0, '0, 16'h0000, 1'b0, act, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        wr_t e, prev, cur;
        logic [31:0] mask;
        bit prev_stall;
        prev_stall = 0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                prev_stall = 0;
            end else begin
                cur.addr = out_addr; cur.data = out_data; cur.be = out_byte_en; cur.cyc = cyc;
                if (prev_stall && out_valid) begin
                    chk("hold_addr", cur.addr, prev.addr);
                    chk("hold_data", cur.data, prev.data);
                    chk("hold_be", cur.be, prev.be);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {out_addr, out_byte_en}, 64'h0);
                        if ({out_addr, out_byte_en} == 30'h0) begin
                            n_bad++;
                            $display("FAIL unexpected_write: got write with be 0, want none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{e.be[k]}};
                        chk("wr_addr", out_addr, e.addr);
                        chk("wr_be", out_byte_en, e.be);
                        chk("wr_data", out_data & mask, e.data);
                    end
                    seen_q.push_back(cur);
                end
                prev_stall = out_valid && !out_ready;
                prev = cur;
            end
        end
    end

    initial begin
        int s0, last, w;
        do_reset();

        // Four sequential bytes complete one word, emitted two cycles after the last byte.
        s0 = seen_q.size();
        step(1, 26'h100, 16'h0011, 0, 1, 1);
        step(1, 26'h101, 16'h0022, 0, 1, 1);
        step(1, 26'h102, 16'h0033, 0, 1, 1);
        step(1, 26'h103, 16'h0044, 0, 1, 1);
        last = cyc;
        idle_steps(4, 1);
        chk("t1_count", seen_q.size() - s0, 1);
        if (seen_q.size() > s0) begin
            chk("t1_addr", seen_q[s0].addr, 26'h100);
            chk("t1_data", seen_q[s0].data, 32'h44332211);
            chk("t1_be", seen_q[s0].be, 4'hF);
            chk("t1_cycle", seen_q[s0].cyc, last + 2);
        end

        // Interleaved surfaces stay open until the flush.
        s0 = seen_q.size();
        step(1, 26'h100, 16'h00A1, 0, 1, 1);
        step(1, 26'h200, 16'h00B1, 0, 1, 1);
        step(1, 26'h101, 16'h00A2, 0, 1, 1);
        step(1, 26'h201, 16'h00B2, 0, 1, 1);
        idle_steps(2, 1);
        chk("t2_nowrite", seen_q.size() - s0, 0);
        idle_steps(4, 0);
        chk("t2_count", seen_q.size() - s0, 2);
        if (seen_q.size() >= s0 + 2) begin
            chk("t2_first", {seen_q[s0].addr, seen_q[s0].be}, {26'h100, 4'h3});
            chk("t2_second", {seen_q[s0+1].addr, seen_q[s0+1].be}, {26'h200, 4'h3});
            chk("t2_consec", seen_q[s0+1].cyc - seen_q[s0].cyc, 1);
        end
        chk("t2_idle", last_idle, 1'b1);

        // Third surface evicts the oldest entry without stalling.
        s0 = seen_q.size();
        step(1, 26'h100, 16'h0001, 0, 1, 1);
        step(1, 26'h200, 16'h0002, 0, 1, 1);
        step(1, 26'h300, 16'h0003, 0, 1, 1);
        w = cyc;
        chk("t3_ready", last_ready, 1'b1);
        idle_steps(1, 1);
        idle_steps(4, 0);
        chk("t3_count", seen_q.size() - s0, 3);
        if (seen_q.size() >= s0 + 3) begin
            chk("t3_evict_addr", seen_q[s0].addr, 26'h100);
            chk("t3_evict_cycle", seen_q[s0].cyc, w + 1);
            chk("t3_open_addr", seen_q[s0+2].addr, 26'h300);
        end

        // Miss with no free entry while the output is stalled.
        step(1, 26'h100, 16'h0005, 0, 1, 1);
        step(1, 26'h200, 16'h0006, 0, 1, 1);
        step(1, 26'h300, 16'h0007, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 26'h400, 16'h0008, 0, 1, 0);
            chk("t4_stall_ready", last_ready, 1'b0);
        end
        step(1, 26'h400, 16'h0008, 0, 1, 1);
        chk("t4_resume_ready", last_ready, 1'b1);
        idle_steps(5, 0);

        // Halfword on the upper half of a word.
        s0 = seen_q.size();
        step(1, 26'h103, 16'hBEEF, 1, 1, 1);
        idle_steps(4, 0);
        chk("t5_count", seen_q.size() - s0, 1);
        if (seen_q.size() > s0) begin
            chk("t5_addr", seen_q[s0].addr, 26'h100);
            chk("t5_be", seen_q[s0].be, 4'hC);
            chk("t5_data", seen_q[s0].data[31:16], 16'hBEEF);
        end

        // Reset discards partial entries and the pending output.
        step(1, 26'h100, 16'h0009, 0, 1, 1);
        step(1, 26'h200, 16'h000A, 0, 1, 1);
        step(1, 26'h300, 16'h000B, 0, 1, 1);
        step(0, '0, 16'h0000, 0, 1, 0);
        s0 = seen_q.size();
        do_reset();
        idle_steps(5, 0);
        idle_steps(3, 1);
        chk("t6_nowrite", seen_q.size() - s0, 0);

        // Randomised traffic over a small address window to force hits, misses and stalls.
        for (int n = 0; n < 2000; n++) begin
            if (n % 700 == 699) do_reset();
            step($urandom_range(0, 3) != 0, 26'h1000 + 26'($urandom_range(0, 23)),
                 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
        end

        // Final drain with a bounded cycle budget.
        for (int i = 0; i < 40 && !last_idle; i++) step(0, '0, 16'h0000, 0, 0, 1);
        chk("drain_idle", last_idle, 1'b1);
        chk("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
